// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame-buffer arbiter: pixel write FIFO, scan-out reads and a clear sweep
// sharing one single-port RAM.
module fb_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int FB_WORDS   = 44160
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  clr_req_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  input  logic                  mem_busy_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  fifo_full_o,
  output logic                  overflow_o,
  input  logic                  overflow_clr_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(FB_WORDS - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
  typedef enum logic [1:0] {G_NONE, G_FIFO, G_READ, G_CLEAR} grant_e;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  ovf_q, rdv_q;
  grant_e                grant;
  logic                  full, pop, push, ovf_set;

  assign full = (cnt_q == DEPTH_C);

  // A full FIFO outranks reads so the TIA write path can never stall indefinitely.
  always_comb begin
    grant = G_NONE;
    if (rst_i || mem_busy_i)        grant = G_NONE;
    else if (full)                  grant = G_FIFO;
    else if (rd_req_i)              grant = G_READ;
    else if (cnt_q != '0)           grant = G_FIFO;
    else if (state_q == ST_CLEAR)   grant = G_CLEAR;
  end

  assign pop     = (grant == G_FIFO);
  assign push    = wr_en_i && (!full || pop);
  assign ovf_set = wr_en_i && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (grant)
      G_FIFO: begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = fifo_addr_q[rp_q];
        mem_wdata_o = fifo_data_q[rp_q];
      end
      G_READ: begin
        mem_en_o   = 1'b1;
        mem_addr_o = rd_addr_i;
      end
      G_CLEAR: begin
        mem_en_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = clr_cnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      ovf_q     <= 1'b0;
      rdv_q     <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr_q[wp_q] <= wr_addr_i;
        fifo_data_q[wp_q] <= wr_data_i;
        wp_q              <= wp_q + PW'(1);
      end
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_d;
      if (ovf_set)             ovf_q <= 1'b1;
      else if (overflow_clr_i) ovf_q <= 1'b0;
      rdv_q <= (grant == G_READ);
      case (state_q)
        ST_IDLE: if (clr_req_i) begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
        end
        ST_CLEAR: if (grant == G_CLEAR) begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          if (clr_cnt_q == LAST_C) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Masking with rst_i keeps a read abandoned by reset from ever showing valid data.
  assign rd_valid_o  = rdv_q && !rst_i;
  assign rd_data_o   = rd_valid_o ? mem_rdata_i : '0;
  assign rd_ack_o    = (grant == G_READ);
  assign clr_busy_o  = (state_q == ST_CLEAR);
  assign clr_done_o  = (grant == G_CLEAR) && (clr_cnt_q == LAST_C);
  assign fifo_full_o = full;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed and random checks of fb_arbiter against a queue-based model.
module tb_fb_arbiter;
  localparam int AW = 16;
  localparam int DW = 7;
  localparam int FBW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i, wr_en_i, rd_req_i, clr_req_i, mem_busy_i, overflow_clr_i;
  logic [AW-1:0] wr_addr_i, rd_addr_i;
  logic [DW-1:0] wr_data_i, mem_rdata_i;
  logic          rd_ack_o, rd_valid_o, clr_busy_o, clr_done_o;
  logic          mem_en_o, mem_we_o, fifo_full_o, overflow_o;
  logic [DW-1:0] rd_data_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .FB_WORDS(FBW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ack_o(rd_ack_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .clr_req_i(clr_req_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .mem_busy_i(mem_busy_i), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .fifo_full_o(fifo_full_o), .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t fq[$];
  bit   m_clear, m_ovf, m_rdv, last_ack;
  int   m_cnt;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    rst_i = 0; wr_en_i = 0; rd_req_i = 0; clr_req_i = 0; mem_busy_i = 0; overflow_clr_i = 0;
    wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_i = 1; wr_addr_i = a; wr_data_i = d;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    int  g, sz;
    bit  novf;
    mem_rdata_i = DW'($urandom);
    @(negedge clk_i);
    sz = fq.size();
    if (rst_i || mem_busy_i) g = 0;
    else if (sz == 4)        g = 1;
    else if (rd_req_i)       g = 2;
    else if (sz > 0)         g = 1;
    else if (m_clear)        g = 3;
    else                     g = 0;
    chk("fifo_full", fifo_full_o, sz == 4);
    chk("mem_en", mem_en_o, g != 0);
    chk("mem_we", mem_we_o, g == 1 || g == 3);
    if (g == 1) begin
      chk("fifo_addr", mem_addr_o, fq[0].a);
      chk("fifo_wdata", mem_wdata_o, fq[0].d);
    end
    if (g == 2) chk("rd_addr", mem_addr_o, rd_addr_i);
    if (g == 3) begin
      chk("clr_addr", mem_addr_o, m_cnt);
      chk("clr_wdata", mem_wdata_o, 0);
    end
    chk("rd_ack", rd_ack_o, g == 2);
    chk("rd_valid", rd_valid_o, m_rdv && !rst_i);
    if (m_rdv && !rst_i) chk("rd_data", rd_data_o, mem_rdata_i);
    chk("clr_busy", clr_busy_o, m_clear);
    chk("clr_done", clr_done_o, g == 3 && m_cnt == FBW - 1);
    chk("overflow", overflow_o, m_ovf);
    last_ack = (g == 2);
    @(posedge clk_i);
    if (rst_i) begin
      fq.delete();
      m_clear = 0; m_cnt = 0; m_ovf = 0; m_rdv = 0;
    end else begin
      novf = 0;
      if (g == 1) void'(fq.pop_front());
      if (wr_en_i) begin
        if (sz < 4 || g == 1) fq.push_back('{wr_addr_i, wr_data_i});
        else novf = 1;
      end
      if (novf) m_ovf = 1;
      else if (overflow_clr_i) m_ovf = 0;
      m_rdv = (g == 2);
      if (m_clear) begin
        if (g == 3) begin
          if (m_cnt == FBW - 1) m_clear = 0;
          m_cnt++;
        end
      end else if (clr_req_i) begin
        m_clear = 1;
        m_cnt = 0;
      end
    end
    #1;
  endtask

  initial begin
    quiet();
    mem_rdata_i = '0;
    m_clear = 0; m_ovf = 0; m_rdv = 0; m_cnt = 0; last_ack = 0;

    rst_i = 1; step(); step();
    rst_i = 0;
    chk("rd_data_rst", rd_data_o, 0);
    step();

    // single write
    push(16'h0123, 7'h2A); step();
    quiet(); step(); step();

    // read beats a one-entry FIFO
    push(16'h0200, 7'h11); step();
    quiet(); rd_req_i = 1; rd_addr_i = 16'h0010; step();
    quiet(); step(); step();

    // full FIFO overrides a held read until occupancy drops
    rd_req_i = 1; rd_addr_i = 16'h0020; mem_busy_i = 1;
    for (int i = 0; i < 4; i++) begin push(AW'(16'h300 + i), DW'(i + 1)); step(); end
    mem_busy_i = 0;
    for (int i = 0; i < 3; i++) begin push(AW'(16'h310 + i), DW'(i + 9)); step(); end
    wr_en_i = 0;
    for (int i = 0; i < 10 && !last_ack; i++) step();
    chk("read_eventually_acked", last_ack, 1);
    quiet();
    for (int i = 0; i < 5; i++) step();

    // overflow, clear, simultaneous set-and-clear, drain in order
    mem_busy_i = 1;
    for (int i = 0; i < 5; i++) begin push(AW'(16'h400 + i), DW'(7'h40 + i)); step(); end
    wr_en_i = 0; overflow_clr_i = 1; step();
    overflow_clr_i = 0; step();
    push(16'h0777, 7'h77); overflow_clr_i = 1; step();
    quiet(); step();
    overflow_clr_i = 1; step();
    quiet();
    for (int i = 0; i < 6; i++) step();

    // full clear sweep
    clr_req_i = 1; step();
    clr_req_i = 0;
    for (int i = 0; i < 11; i++) step();

    // reset mid-clear
    clr_req_i = 1; step();
    clr_req_i = 0;
    for (int i = 0; i < 3; i++) step();
    chk("clr_cnt_at_reset", m_cnt, 3);
    rst_i = 1; step();
    rst_i = 0;
    for (int i = 0; i < 4; i++) step();

    // reset with a read in flight
    rd_req_i = 1; rd_addr_i = 16'h0055; step();
    quiet(); rst_i = 1; step();
    rst_i = 0; step(); step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (!(rd_req_i && !last_ack)) begin
        rd_req_i  = ($urandom_range(0, 2) == 0);
        rd_addr_i = AW'($urandom);
      end
      wr_en_i        = $urandom_range(0, 1);
      wr_addr_i      = AW'($urandom);
      wr_data_i      = DW'($urandom);
      mem_busy_i     = ($urandom_range(0, 3) == 0);
      clr_req_i      = ($urandom_range(0, 49) == 0);
      overflow_clr_i = ($urandom_range(0, 9) == 0);
      rst_i          = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, frame-buffer word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 7, pixel colour width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel write FIFO entries (power of two, at least 2).
REQ-004 SHALL have parameter FB_WORDS, default 44160, number of words swept by a clear.
REQ-005 SHALL have ports: clk_i in 1, sole clock; rst_i in 1, reset, synchronous and active-high.
REQ-006 SHALL have ports: wr_en_i in 1, wr_addr_i in ADDR_WIDTH, wr_data_i in DATA_WIDTH; these carry the TIA pixel write.
REQ-007 SHALL have ports: rd_req_i in 1, rd_addr_i in ADDR_WIDTH, rd_ack_o out 1, rd_data_o out DATA_WIDTH, rd_valid_o out 1; these form the scan-out read port.
REQ-008 SHALL have ports: clr_req_i in 1, clr_busy_o out 1, clr_done_o out 1.
REQ-009 SHALL have ports: mem_busy_i in 1, mem_en_o out 1, mem_we_o out 1, mem_addr_o out ADDR_WIDTH, mem_wdata_o out DATA_WIDTH, mem_rdata_i in DATA_WIDTH; these drive a single-port RAM with 1-cycle read latency.
REQ-010 SHALL have ports: fifo_full_o out 1, overflow_o out 1 (sticky), overflow_clr_i in 1.

Function
REQ-011 SHALL push {wr_addr_i, wr_data_i} into the FIFO on every cycle wr_en_i=1.
REQ-012 SHALL allow push and pop in the same cycle at any occupancy, including full.
REQ-013 SHALL drop the push and set overflow_o when wr_en_i=1, the FIFO is full, and no pop occurs that cycle; FIFO contents SHALL stay unchanged.
REQ-014 SHALL assert fifo_full_o combinationally when occupancy equals FIFO_DEPTH.
REQ-015 SHALL decide one grant per cycle with this priority: mem_busy_i=1 gives no grant; else FIFO full gives a FIFO write; else rd_req_i gives a read; else FIFO non-empty gives a FIFO write; else state CLEAR gives a clear write; else idle.
REQ-016 SHALL, on a FIFO write grant, pop the head and drive mem_en_o=1, mem_we_o=1, mem_addr_o=head address and mem_wdata_o=head data in the same cycle.
REQ-017 SHALL, on a read grant, drive mem_en_o=1, mem_we_o=0 and mem_addr_o=rd_addr_i, and pulse rd_ack_o for that one cycle.
REQ-018 SHALL, in the cycle after a read grant, drive rd_data_o=mem_rdata_i and rd_valid_o=1; rd_valid_o SHALL be 0 otherwise.
REQ-019 The reader holds rd_req_i and rd_addr_i until rd_ack_o; arbiter behaviour when rd_addr_i changes before ack is don't-care.
REQ-020 SHALL drive mem_en_o=0 and mem_we_o=0 on idle and mem_busy_i cycles; mem_addr_o and mem_wdata_o are don't-care there.
REQ-021 SHALL implement the clear FSM with two states: IDLE and CLEAR.
REQ-022 SHALL go IDLE->CLEAR on clr_req_i=1, with clr_cnt=0; clr_req_i SHALL be ignored while in CLEAR.
REQ-023 SHALL, on a clear write grant, drive mem_en_o=1, mem_we_o=1, mem_addr_o=clr_cnt and mem_wdata_o=0, then increment clr_cnt.
REQ-024 SHALL, on the clear grant with clr_cnt=FB_WORDS-1, return to IDLE and pulse clr_done_o for 1 cycle; clr_busy_o SHALL be 1 exactly while in CLEAR.
REQ-025 Pixel writes granted during CLEAR may later be overwritten by the sweep; this is accepted behaviour.
REQ-026 SHALL clear overflow_o on overflow_clr_i=1; a simultaneous new overflow SHALL win and leave overflow_o=1.

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge: empty the FIFO, set state IDLE, set clr_cnt=0, and set rd_ack_o, rd_valid_o, clr_busy_o, clr_done_o, mem_en_o, mem_we_o, overflow_o and fifo_full_o all to 0, with rd_data_o=0.
REQ-028 SHALL, on reset during CLEAR or with a read in flight, abandon the operation with no clr_done_o pulse and no rd_valid_o.
REQ-029 SHALL grant nothing in the reset cycle.

Verification
REQ-030 Single write: wr_en_i with addr 0x0123 and data 0x2A, no reads -> next cycle mem write to 0x0123 with data 0x2A; FIFO empty afterwards.
REQ-031 Read priority: FIFO holds 1 entry and rd_req_i addr 0x0010 -> read granted first with rd_ack_o=1, write granted next cycle, rd_valid_o with mem_rdata_i in the cycle after the read grant.
REQ-032 Full override: fill FIFO to 4 while rd_req_i held -> write granted and rd_ack_o=0 until occupancy drops below 4.
REQ-033 Overflow: mem_busy_i=1 and 5 consecutive pushes -> 4 stored, overflow_o=1; overflow_clr_i -> 0; release busy -> 4 writes drained in order.
REQ-034 Clear: FB_WORDS=8 and clr_req_i pulse, no other traffic -> writes of 0 to addresses 0..7 on 8 consecutive cycles, clr_done_o on the 8th, clr_busy_o falls after it.
REQ-035 Reset mid-clear: rst_i at clr_cnt=3 -> clr_busy_o=0, no clr_done_o, no further mem writes.
